// File: rtl/mem_wait_responder.sv
//==============================================================================
// Module      : mem_wait_responder
// Description : Single-port memory responder with 0..3 programmable wait states.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module mem_wait_responder #(
   parameter int DW = 32,
   parameter int AW = 4
) (
   input  logic          Clk,
   input  logic          Rst_n,
   input  logic          Req,
   input  logic          Write,
   input  logic [AW-1:0] Addr,
   input  logic [DW-1:0] WData,
   input  logic [1:0]    WaitCfg,
   output logic          Ready,
   output logic [DW-1:0] RData,
   output logic          Busy
);

   localparam logic [1:0] c_S_IDLE = 2'd0;
   localparam logic [1:0] c_S_WAIT = 2'd1;
   localparam logic [1:0] c_S_RESP = 2'd2;

   logic [1:0]    r_state;
   logic [1:0]    w_state_nxt;
   logic [1:0]    r_cnt;
   logic          r_write;
   logic [AW-1:0] r_addr;
   logic [DW-1:0] r_wdata;
   logic [DW-1:0] r_rdata;
   logic          r_ready;
   logic          r_busy;
   logic          w_ready_nxt;
   logic          w_busy_nxt;
   logic          w_accept;
   logic          w_access;
   logic [DW-1:0] r_mem [2**AW];

   assign w_accept = Req && ((r_state == c_S_IDLE) || (r_state == c_S_RESP));
   // Access fires on the WAIT->RESP edge; gated by reset so an aborted write never lands.
   assign w_access = (r_state == c_S_WAIT) && (r_cnt == 2'd0) && Rst_n;

   // State register
   always_ff @(posedge Clk) begin
      if (!Rst_n) begin
         r_state <= c_S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_S_IDLE: if (w_accept) w_state_nxt = c_S_WAIT;
         c_S_WAIT: if (r_cnt == 2'd0) w_state_nxt = c_S_RESP;
         c_S_RESP: w_state_nxt = w_accept ? c_S_WAIT : c_S_IDLE;
         default:  w_state_nxt = c_S_IDLE;
      endcase
   end

   // Output logic, decoded from the next state so Ready/Busy come from flops
   always_comb begin
      w_ready_nxt = (w_state_nxt == c_S_RESP);
      w_busy_nxt  = (w_state_nxt == c_S_WAIT);
   end

   always_ff @(posedge Clk) begin
      if (!Rst_n) begin
         r_ready <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         r_ready <= w_ready_nxt;
         r_busy  <= w_busy_nxt;
      end
   end

   always_ff @(posedge Clk) begin
      if (!Rst_n) begin
         r_cnt   <= 2'd0;
         r_write <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_rdata <= '0;
      end else begin
         if (w_accept) begin
            r_cnt   <= WaitCfg;
            r_write <= Write;
            r_addr  <= Addr;
            r_wdata <= WData;
         end else if ((r_state == c_S_WAIT) && (r_cnt != 2'd0)) begin
            r_cnt <= r_cnt - 2'd1;
         end
         if (w_access && !r_write) begin
            r_rdata <= r_mem[r_addr];
         end
      end
   end

   // Array is intentionally not reset
   always_ff @(posedge Clk) begin
      if (w_access && r_write) begin
         r_mem[r_addr] <= r_wdata;
      end
   end

   assign Ready = r_ready;
   assign Busy  = r_busy;
   assign RData = r_rdata;

endmodule

`default_nettype wire

// File: tb/tb_mem_wait_responder.sv
//==============================================================================
// Module      : tb_mem_wait_responder
// Description : Directed self-checking bench for mem_wait_responder.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_mem_wait_responder;

   localparam int DW = 32;
   localparam int AW = 4;

   logic          Clk = 1'b0;
   logic          Rst_n = 1'b0;
   logic          Req = 1'b0;
   logic          Write = 1'b0;
   logic [AW-1:0] Addr = '0;
   logic [DW-1:0] WData = '0;
   logic [1:0]    WaitCfg = 2'd0;
   logic          Ready;
   logic [DW-1:0] RData;
   logic          Busy;

   int n_checks = 0;
   int n_fail   = 0;

   mem_wait_responder #(.DW(DW), .AW(AW)) dut (
      .Clk     (Clk),
      .Rst_n   (Rst_n),
      .Req     (Req),
      .Write   (Write),
      .Addr    (Addr),
      .WData   (WData),
      .WaitCfg (WaitCfg),
      .Ready   (Ready),
      .RData   (RData),
      .Busy    (Busy)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // One isolated transaction: returns Ready latency in negedge samples, Busy count and RData at Ready
   task automatic xact(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [1:0] wc, output int lat, output int nbusy,
                       output logic [DW-1:0] rd);
      lat = 99;
      nbusy = 0;
      rd = '0;
      @(negedge Clk);
      Req = 1'b1; Write = w; Addr = a; WData = d; WaitCfg = wc;
      @(posedge Clk);
      #1 Req = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         @(negedge Clk);
         if (Busy) nbusy++;
         if (Ready) begin
            lat = k;
            rd = RData;
            break;
         end
      end
      @(negedge Clk);
      chk("ready_single_pulse", {31'd0, Ready}, 32'd0);
   endtask

   int lat, nb;
   logic [DW-1:0] rd;

   initial begin
      // Reset, with Req asserted to confirm it is ignored
      Req = 1'b1; Write = 1'b1; Addr = 4'd2; WaitCfg = 2'd0;
      repeat (2) @(posedge Clk);
      @(negedge Clk);
      chk("rst_ready", {31'd0, Ready}, 32'd0);
      chk("rst_busy",  {31'd0, Busy},  32'd0);
      chk("rst_rdata", RData, 32'd0);
      Req = 1'b0; Rst_n = 1'b1;

      xact(1'b1, 4'd3, 32'hDEADBEEF, 2'd0, lat, nb, rd);
      chk("wr_w0_lat",   lat, 32'd2);
      chk("wr_w0_busy",  nb,  32'd1);
      chk("wr_w0_rdata", rd,  32'd0);

      xact(1'b0, 4'd3, 32'h0, 2'd0, lat, nb, rd);
      chk("rd_w0_lat",   lat, 32'd2);
      chk("rd_w0_rdata", rd,  32'hDEADBEEF);

      xact(1'b0, 4'd3, 32'h0, 2'd3, lat, nb, rd);
      chk("rd_w3_lat",   lat, 32'd5);
      chk("rd_w3_busy",  nb,  32'd4);
      chk("rd_w3_rdata", rd,  32'hDEADBEEF);

      // Back-to-back reads, Req held high, WaitCfg=1, alternating addresses
      xact(1'b1, 4'd8, 32'h0000A5A5, 2'd1, lat, nb, rd);
      xact(1'b1, 4'd9, 32'h00005A5A, 2'd1, lat, nb, rd);
      @(negedge Clk);
      Req = 1'b1; Write = 1'b0; Addr = 4'd8; WaitCfg = 2'd1;
      for (int i = 0; i < 9; i++) begin
         @(negedge Clk);
         chk("b2b_ready", {31'd0, Ready}, (i % 3 == 2) ? 32'd1 : 32'd0);
         chk("b2b_busy",  {31'd0, Busy},  (i % 3 == 2) ? 32'd0 : 32'd1);
         if (i % 3 == 2) begin
            chk("b2b_rdata", RData, (i == 5) ? 32'h00005A5A : 32'h0000A5A5);
            Addr = (Addr == 4'd8) ? 4'd9 : 4'd8;
            if (i == 8) Req = 1'b0;
         end
      end

      // Reset aborts an in-flight write
      xact(1'b1, 4'd5, 32'h11111111, 2'd0, lat, nb, rd);
      @(negedge Clk);
      Req = 1'b1; Write = 1'b1; Addr = 4'd5; WData = 32'h22222222; WaitCfg = 2'd3;
      @(posedge Clk);
      #1 Req = 1'b0;
      for (int k = 0; k < 2; k++) begin
         @(negedge Clk);
         chk("abort_no_ready", {31'd0, Ready}, 32'd0);
         chk("abort_busy",     {31'd0, Busy},  32'd1);
      end
      Rst_n = 1'b0;
      @(negedge Clk);
      chk("abort_rst_ready", {31'd0, Ready}, 32'd0);
      chk("abort_rst_busy",  {31'd0, Busy},  32'd0);
      chk("abort_rst_rdata", RData, 32'd0);
      Rst_n = 1'b1;
      xact(1'b0, 4'd5, 32'h0, 2'd0, lat, nb, rd);
      chk("abort_mem_kept", rd, 32'h11111111);

      // Inputs changed during WAIT must be ignored
      xact(1'b1, 4'd1, 32'h01010101, 2'd0, lat, nb, rd);
      xact(1'b1, 4'd7, 32'h07070707, 2'd0, lat, nb, rd);
      @(negedge Clk);
      Req = 1'b1; Write = 1'b0; Addr = 4'd1; WaitCfg = 2'd2;
      @(posedge Clk);
      #1 Req = 1'b0;
      lat = 99;
      nb = 0;
      for (int k = 1; k <= 8; k++) begin
         @(negedge Clk);
         if (Ready) begin
            nb++;
            if (lat == 99) begin
               lat = k;
               chk("ign_rdata", RData, 32'h01010101);
            end
         end
         if (k == 1) begin
            Req = 1'b1; Write = 1'b1; Addr = 4'd7; WData = 32'hBADBAD00; WaitCfg = 2'd0;
         end
         if (k == 3) Req = 1'b0;
      end
      chk("ign_lat",    lat, 32'd4);
      chk("ign_pulses", nb,  32'd1);
      xact(1'b0, 4'd7, 32'h0, 2'd0, lat, nb, rd);
      chk("ign_mem7", rd, 32'h07070707);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule

`default_nettype wire

// File: doc/mem_wait_responder.md
MEM_WAIT_RESPONDER -- requirements
Module: mem_wait_responder

Interface
REQ-001 The block SHALL have parameter DW, default 32, meaning data width in bits.
REQ-002 The block SHALL have parameter AW, default 4, meaning word-address width; array depth is 2**AW words.
REQ-003 The block SHALL have port Clk  input  1  system clock; all state changes on posedge Clk.
REQ-004 The block SHALL have port Rst_n  input  1  reset, synchronous, active-low.
REQ-005 The block SHALL have port Req  input  1  access request, sampled only in IDLE or RESP.
REQ-006 The block SHALL have port Write  input  1  1 = write, 0 = read; sampled with Req.
REQ-007 The block SHALL have port Addr  input  AW  word address; sampled with Req.
REQ-008 The block SHALL have port WData  input  DW  write data; sampled with Req.
REQ-009 The block SHALL have port WaitCfg  input  2  wait-state count 0..3; sampled with Req.
REQ-010 The block SHALL have port Ready  output  1  one-cycle completion pulse, registered.
REQ-011 The block SHALL have port RData  output  DW  read data, registered; valid while Ready=1 and held afterwards.
REQ-012 The block SHALL have port Busy  output  1  high exactly while state = WAIT.

Function
REQ-013 The block SHALL implement FSM states IDLE, WAIT, RESP, plus a 2-bit down-counter Cnt.
REQ-014 In IDLE or RESP, Req=1 at an edge SHALL latch Write/Addr/WData/WaitCfg, load Cnt<=WaitCfg, and go to WAIT.
REQ-015 In IDLE with Req=0, the block SHALL stay in IDLE; in RESP with Req=0, it SHALL go to IDLE.
REQ-016 In WAIT with Cnt!=0, the block SHALL decrement Cnt and stay in WAIT; with Cnt=0 it SHALL go to RESP.
REQ-017 On the WAIT->RESP edge, the block SHALL perform the access: a write stores latched WData to mem[latched Addr]; a read loads RData<=mem[latched Addr].
REQ-018 Ready SHALL be 1 exactly during RESP cycles and 0 otherwise; request accepted at edge T gives Ready high in the cycle after edge T+1+W (W = latched WaitCfg).
REQ-019 Req, Write, Addr, WData and WaitCfg SHALL be ignored while in WAIT; the latched values govern the whole transaction.
REQ-020 A write SHALL leave RData unchanged; RData SHALL change only on read completion.
REQ-021 Read-after-write to the same address SHALL return the newly written data (write committed at its RESP edge precedes any later read's RESP edge).
REQ-022 Back-to-back: Req=1 during RESP SHALL be accepted with no idle cycle; Ready SHALL then drop for at least one cycle (W+1 cycles of WAIT).
REQ-023 Cnt SHALL never wrap; it stops at 0 when it leaves WAIT.
REQ-024 Memory array contents SHALL NOT be reset and are undefined until written.

Reset
REQ-025 With Rst_n=0 at an edge, the block SHALL set state=IDLE, Cnt=0, Ready=0, RData=0, Busy=0, overriding all other inputs.
REQ-026 Reset during WAIT SHALL abort the transaction; a pending write SHALL NOT modify the array, and no Ready pulse SHALL be produced.
REQ-027 Req=1 in the cycle Rst_n=0 SHALL be ignored; the first acceptance is possible at the first edge with Rst_n=1.

Verification
REQ-028 Write, WaitCfg=0, Addr=3, WData=0xDEADBEEF, then read Addr=3, WaitCfg=0 -> the write's Ready comes 2 edges after acceptance with RData unchanged (0); the read's Ready comes with RData=0xDEADBEEF.
REQ-029 Read, WaitCfg=3 -> Busy high for 4 cycles; Ready high 5 edges after acceptance for exactly 1 cycle.
REQ-030 Req held high continuously, WaitCfg=1, alternating addresses -> Ready pulses every 3 cycles; Busy low only in RESP cycles.
REQ-031 Write Addr=5, WaitCfg=3, Rst_n=0 after 2 WAIT cycles, then read Addr=5 -> no Ready before reset; Addr=5 keeps its prior value (preload 0x11111111 -> read returns 0x11111111).
REQ-032 During WAIT of a read at Addr=1 (WaitCfg=2), drive Req=1, Addr=7, WaitCfg=0 -> ignored: exactly one Ready, RData=mem[1], completion at the WaitCfg=2 timing.
REQ-033 Reset from any state -> Ready=0, Busy=0, RData=0 on the next cycle.
